// File: rtl/tlb_multiport.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tlb_multiport
//
// Fully-associative, dual-page TLB with NUM_PORTS independent registered
// search ports. It also has a write port with hardware random replacement
// above a wired boundary, a registered read-back port, and a sequential flush
// engine that can clear all entries or only the non-global entries of one ASID.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   s_valid/s_vpn2/     per-port search request (port p in slice p)
//   s_odd_page/s_asid
//   r_valid/r_found/    per-port registered search result, one cycle after
//   r_multi/r_index/    s_valid; held when no request was made
//   r_pfn/r_c/r_d/r_v
//   we/w_use_random/    entry write, at random_index or at w_index
//   w_index/w_entry
//   wired/random_index  random-replacement lower bound / current index
//   rd_index/rd_entry/  registered entry read-back
//   rd_live
//   flush_req/          flush start pulse, mode and ASID
//   flush_by_asid/
//   flush_asid
//   flush_busy/         sweep in progress / one-cycle completion pulse
//   flush_done
//
// Entry packing (78 bits, MSB first):
//   {vpn2[19], asid[8], g, pfn0[20], c0[3], d0, v0, pfn1[20], c1[3], d1, v1}
// -----------------------------------------------------------------------------
module tlb_multiport #(
   parameter int NUM_ENTRIES = 16,
   parameter int NUM_PORTS   = 2,
   localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_PORTS-1:0]      s_valid,
   input  logic [19*NUM_PORTS-1:0]   s_vpn2,
   input  logic [NUM_PORTS-1:0]      s_odd_page,
   input  logic [8*NUM_PORTS-1:0]    s_asid,
   output logic [NUM_PORTS-1:0]      r_valid,
   output logic [NUM_PORTS-1:0]      r_found,
   output logic [NUM_PORTS-1:0]      r_multi,
   output logic [IDX_W*NUM_PORTS-1:0] r_index,
   output logic [20*NUM_PORTS-1:0]   r_pfn,
   output logic [3*NUM_PORTS-1:0]    r_c,
   output logic [NUM_PORTS-1:0]      r_d,
   output logic [NUM_PORTS-1:0]      r_v,
   input  logic                      we,
   input  logic                      w_use_random,
   input  logic [IDX_W-1:0]          w_index,
   input  logic [77:0]               w_entry,
   input  logic [IDX_W-1:0]          wired,
   output logic [IDX_W-1:0]          random_index,
   input  logic [IDX_W-1:0]          rd_index,
   output logic [77:0]               rd_entry,
   output logic                      rd_live,
   input  logic                      flush_req,
   input  logic                      flush_by_asid,
   input  logic [7:0]                flush_asid,
   output logic                      flush_busy,
   output logic                      flush_done
);

   // Field positions inside a packed entry
   localparam int VPN_LO  = 59;
   localparam int ASID_LO = 51;
   localparam int G_BIT   = 50;
   localparam int PFN0_LO = 30;
   localparam int C0_LO   = 27;
   localparam int D0_BIT  = 26;
   localparam int V0_BIT  = 25;
   localparam int PFN1_LO = 5;
   localparam int C1_LO   = 2;
   localparam int D1_BIT  = 1;
   localparam int V1_BIT  = 0;

   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } flush_state_t;

   // Entry storage. Fields are never reset; only the live bits are.
   logic [77:0]            entry_mem [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] live_reg;

   logic [IDX_W-1:0] random_reg;
   logic [IDX_W-1:0] w_target;

   flush_state_t     state_reg, state_next;
   logic [IDX_W-1:0] cnt_reg, cnt_next;
   logic             mode_reg, mode_next;   // 1 = by ASID
   logic [7:0]       asid_reg, asid_next;
   logic             flush_clr;

   assign w_target     = w_use_random ? random_reg : w_index;
   assign random_index = random_reg;

   // ---------------------------------------------------------------- storage
   always_ff @(posedge clock) begin
      if (we) begin
         entry_mem[w_target] <= w_entry;
      end
   end

   // A write issued in the same cycle as a sweep clear of that entry wins,
   // because it is applied after the clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         live_reg <= '0;
      end else begin
         if (flush_clr) begin
            live_reg[cnt_reg] <= 1'b0;
         end
         if (we) begin
            live_reg[w_target] <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- random
   // Wraps to the top whenever it has reached (or fallen below) wired, which
   // also covers wired being raised above the current value and wired >= top.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         random_reg <= MAX_IDX;
      end else if (random_reg <= wired) begin
         random_reg <= MAX_IDX;
      end else begin
         random_reg <= random_reg - 1'b1;
      end
   end

   // ---------------------------------------------------------------- read
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_entry <= '0;
         rd_live  <= 1'b0;
      end else begin
         rd_entry <= entry_mem[rd_index];
         rd_live  <= live_reg[rd_index];
      end
   end

   // ---------------------------------------------------------------- flush
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         mode_reg  <= 1'b0;
         asid_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         mode_reg  <= mode_next;
         asid_reg  <= asid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mode_next  = mode_reg;
      asid_next  = asid_reg;
      flush_clr  = 1'b0;
      flush_busy = 1'b0;
      flush_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (flush_req) begin
               mode_next  = flush_by_asid;
               asid_next  = flush_asid;
               cnt_next   = '0;
               state_next = SWEEP;
            end
         end
         SWEEP: begin
            flush_busy = 1'b1;
            flush_clr  = !mode_reg ||
                         (!entry_mem[cnt_reg][G_BIT] &&
                          entry_mem[cnt_reg][ASID_LO +: 8] == asid_reg);
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == MAX_IDX) begin
               state_next = DONE;
            end
         end
         DONE: begin
            flush_done = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- search
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         logic [18:0]            vpn;
         logic [7:0]             asid;
         logic [NUM_ENTRIES-1:0] hit;
         logic                   found;
         logic                   multi;
         logic [IDX_W-1:0]       idx;
         logic [19:0]            pfn;
         logic [2:0]             c;
         logic                   d;
         logic                   v;

         logic                   valid_reg;
         logic                   found_reg;
         logic                   multi_reg;
         logic [IDX_W-1:0]       idx_reg;
         logic [19:0]            pfn_reg;
         logic [2:0]             c_reg;
         logic                   d_reg;
         logic                   v_reg;

         assign vpn  = s_vpn2[19*gi +: 19];
         assign asid = s_asid[8*gi +: 8];

         always_comb begin
            hit = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
               hit[i] = live_reg[i] &&
                        (entry_mem[i][VPN_LO +: 19] == vpn) &&
                        (entry_mem[i][G_BIT] || entry_mem[i][ASID_LO +: 8] == asid);
            end
         end

         // Lowest matching index wins; clearing the lowest set bit leaves
         // something only if more than one entry matched.
         always_comb begin
            idx = '0;
            for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
               if (hit[i]) begin
                  idx = IDX_W'(i);
               end
            end
            found = |hit;
            multi = (hit & (hit - 1'b1)) != '0;
         end

         always_comb begin
            pfn = '0;
            c   = '0;
            d   = 1'b0;
            v   = 1'b0;
            if (found) begin
               if (s_odd_page[gi]) begin
                  pfn = entry_mem[idx][PFN1_LO +: 20];
                  c   = entry_mem[idx][C1_LO +: 3];
                  d   = entry_mem[idx][D1_BIT];
                  v   = entry_mem[idx][V1_BIT];
               end else begin
                  pfn = entry_mem[idx][PFN0_LO +: 20];
                  c   = entry_mem[idx][C0_LO +: 3];
                  d   = entry_mem[idx][D0_BIT];
                  v   = entry_mem[idx][V0_BIT];
               end
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               valid_reg <= 1'b0;
               found_reg <= 1'b0;
               multi_reg <= 1'b0;
               idx_reg   <= '0;
               pfn_reg   <= '0;
               c_reg     <= '0;
               d_reg     <= 1'b0;
               v_reg     <= 1'b0;
            end else begin
               valid_reg <= s_valid[gi];
               if (s_valid[gi]) begin
                  found_reg <= found;
                  multi_reg <= multi;
                  idx_reg   <= idx;
                  pfn_reg   <= pfn;
                  c_reg     <= c;
                  d_reg     <= d;
                  v_reg     <= v;
               end
            end
         end

         assign r_valid[gi]             = valid_reg;
         assign r_found[gi]             = found_reg;
         assign r_multi[gi]             = multi_reg;
         assign r_index[IDX_W*gi +: IDX_W] = idx_reg;
         assign r_pfn[20*gi +: 20]      = pfn_reg;
         assign r_c[3*gi +: 3]          = c_reg;
         assign r_d[gi]                 = d_reg;
         assign r_v[gi]                 = v_reg;
      end
   endgenerate

endmodule
